// File: rtl/ov_stream_pkg.sv
// Shared types and default timing for the OV-style camera stream generator.
package ov_stream_pkg;

    localparam int unsigned H_ACTIVE_DEF     = 160;
    localparam int unsigned V_ACTIVE_DEF     = 120;
    localparam int unsigned H_BLANK_DEF      = 16;
    localparam int unsigned V_SYNC_LINES_DEF = 3;
    localparam int unsigned V_BP_LINES_DEF   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVbp,
        StAct,
        StHbl
    } state_t;

    typedef struct packed {
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
    } pixel565_t;

    // RGB565 is sent high byte first: {R,G[5:3]} then {G[2:0],B}.
    function automatic logic [7:0] pixel_byte(input pixel565_t p, input logic lo);
        return lo ? {p.g6[2:0], p.b5} : {p.r5, p.g6[5:3]};
    endfunction

endpackage

// File: rtl/ov_pattern_gen.sv
// Combinational test-pattern source: coordinate gradient by default, or a
// black/white checkerboard when PATTERN_CHECKER_EN is defined.
module ov_pattern_gen
    import ov_stream_pkg::*;
(
    input  logic [4:0] i_x,
    input  logic [5:0] i_y,
    input  logic [7:0] i_frame_cnt,
    output pixel565_t  o_pixel
);

`ifdef PATTERN_CHECKER_EN
    logic w_unused;
    assign w_unused = ^{i_x[4], i_x[2:0], i_y[5:4], i_y[2:0], i_frame_cnt};
    assign o_pixel  = (i_x[3] ^ i_y[3]) ? pixel565_t'(16'hFFFF) : pixel565_t'(16'h0000);
`else
    logic w_unused;
    assign w_unused = ^i_frame_cnt[7:5];
    assign o_pixel  = '{r5: i_x, g6: i_y, b5: i_frame_cnt[4:0]};
`endif

endmodule

// File: rtl/ov_stream_gen.sv
// OV-camera-like byte stream generator (pclk = clk/4, vsync/HREF/data).
// Pixel pattern selected by PATTERN_CHECKER_EN; timing is identical either way.
module ov_stream_gen
    import ov_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned H_BLANK      = H_BLANK_DEF,
    parameter int unsigned V_SYNC_LINES = V_SYNC_LINES_DEF,
    parameter int unsigned V_BP_LINES   = V_BP_LINES_DEF
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    output logic       pclk,
    output logic       vsync,
    output logic       hsync,
    output logic [7:0] data,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int unsigned LINE_T = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned TW     = $clog2(LINE_T + 1);
    localparam int unsigned V_MAX0 = (V_ACTIVE > V_SYNC_LINES) ? V_ACTIVE : V_SYNC_LINES;
    localparam int unsigned V_MAX  = (V_MAX0 > V_BP_LINES) ? V_MAX0 : V_BP_LINES;
    localparam int unsigned LW     = $clog2(V_MAX + 1);

    state_t        r_state, w_state_d;
    logic [1:0]    r_div;
    logic [TW-1:0] r_tcnt, w_tcnt_d;
    logic [LW-1:0] r_lcnt, w_lcnt_d;
    logic          r_start, w_start_d;
    logic [7:0]    r_frame_cnt;
    logic          w_tick, w_line_end, w_frame_end;
    logic [4:0]    w_x;
    logic [5:0]    w_y;
    pixel565_t     w_pixel;

    assign w_tick     = (r_div == 2'd3);
    assign w_line_end = (r_tcnt == TW'(LINE_T - 1));

    // The start latch only lives in IDLE, so a start seen while busy is dropped.
    assign w_start_d = (r_state == StIdle) && !w_tick && (r_start || start);

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_state     <= StIdle;
            r_tcnt      <= '0;
            r_lcnt      <= '0;
            r_start     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_div   <= r_div + 2'd1;
            r_start <= w_start_d;
            if (w_tick) begin
                r_state <= w_state_d;
                r_tcnt  <= w_tcnt_d;
                r_lcnt  <= w_lcnt_d;
            end
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // r_tcnt counts ticks within the current phase; r_lcnt counts lines (or y in ACT/HBL).
    always_comb begin
        w_state_d   = r_state;
        w_tcnt_d    = r_tcnt + TW'(1);
        w_lcnt_d    = r_lcnt;
        w_frame_end = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_tcnt_d = '0;
                w_lcnt_d = '0;
                if (r_start || start) begin
                    w_state_d = StVsync;
                end
            end
            StVsync: begin
                if (w_line_end) begin
                    w_tcnt_d = '0;
                    if (r_lcnt == LW'(V_SYNC_LINES - 1)) begin
                        w_lcnt_d  = '0;
                        w_state_d = StVbp;
                    end else begin
                        w_lcnt_d = r_lcnt + LW'(1);
                    end
                end
            end
            StVbp: begin
                if (w_line_end) begin
                    w_tcnt_d = '0;
                    if (r_lcnt == LW'(V_BP_LINES - 1)) begin
                        w_lcnt_d  = '0;
                        w_state_d = StAct;
                    end else begin
                        w_lcnt_d = r_lcnt + LW'(1);
                    end
                end
            end
            StAct: begin
                if (r_tcnt == TW'(2 * H_ACTIVE - 1)) begin
                    w_tcnt_d  = '0;
                    w_state_d = StHbl;
                end
            end
            StHbl: begin
                if (r_tcnt == TW'(H_BLANK - 1)) begin
                    w_tcnt_d = '0;
                    if (r_lcnt != LW'(V_ACTIVE - 1)) begin
                        w_lcnt_d  = r_lcnt + LW'(1);
                        w_state_d = StAct;
                    end else begin
                        w_lcnt_d    = '0;
                        w_frame_end = w_tick;
                        w_state_d   = continuous ? StVsync : StIdle;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_x = 5'(r_tcnt >> 1);
    assign w_y = 6'(r_lcnt);

    ov_pattern_gen u_pattern_gen (
        .i_x         (w_x),
        .i_y         (w_y),
        .i_frame_cnt (r_frame_cnt),
        .o_pixel     (w_pixel)
    );

    assign pclk       = r_div[1];
    assign vsync      = (r_state == StVsync);
    assign hsync      = (r_state == StAct);
    assign data       = hsync ? pixel_byte(w_pixel, r_tcnt[0]) : 8'h00;
    assign busy       = (r_state != StIdle);
    assign frame_done = w_frame_end;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ov_stream_gen.sv
// Directed bench for ov_stream_gen with a tiny frame geometry.
module tb_ov_stream_gen;

`ifdef PATTERN_CHECKER_EN
    localparam int unsigned HA = 16;
`else
    localparam int unsigned HA = 4;
`endif
    localparam int unsigned VA = 2;
    localparam int unsigned HB = 2;
    localparam int unsigned VS = 1;
    localparam int unsigned VB = 1;
    localparam int unsigned LT = 2 * HA + HB;
    localparam int unsigned FRAME_T = (VS + VB + VA) * LT;
    localparam int CAP_CLKS = int'(FRAME_T) * 4 + 200;

    logic       clk_100MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       pclk, vsync, hsync, busy, frame_done;
    logic [7:0] data, frame_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int done_total = 0;

    // Capture results
    int n_vs, n_hs, n_win, n_gap, n_blank_bad, first_hs, n_last_pos;
    bit timed_out;
    logic [7:0] q_data[$];
    int q_pos[$];
    int q_fidx[$];

    ov_stream_gen #(
        .H_ACTIVE     (HA),
        .V_ACTIVE     (VA),
        .H_BLANK      (HB),
        .V_SYNC_LINES (VS),
        .V_BP_LINES   (VB)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .pclk       (pclk),
        .vsync      (vsync),
        .hsync      (hsync),
        .data       (data),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(negedge clk_100MHz) if (frame_done === 1'b1) done_total++;

    task automatic apply_reset;
        start = 1'b0;
        continuous = 1'b0;
        @(negedge clk_100MHz);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        rst_n = 1'b1;
        @(negedge clk_100MHz);
    endtask

    task automatic pulse_start;
        @(negedge clk_100MHz);
        start = 1'b1;
        @(negedge clk_100MHz);
        start = 1'b0;
    endtask

    // Samples one record per pclk rising edge until busy drops after nf frames.
    task automatic capture(input int nf, input int max_clks);
        logic prev_pclk;
        bit started, prev_hs;
        int done0, idx, pos;
        done0 = done_total;
        started = 0; prev_hs = 0; idx = 0; pos = 0;
        n_vs = 0; n_hs = 0; n_win = 0; n_gap = 0; n_blank_bad = 0; first_hs = -1;
        n_last_pos = 0;
        q_data.delete(); q_pos.delete(); q_fidx.delete();
        timed_out = 1;
        prev_pclk = pclk;
        for (int c = 0; c < max_clks; c++) begin
            @(posedge clk_100MHz);
            #1;
            if (done_total - done0 >= nf - 1) continuous = 1'b0;
            if (pclk && !prev_pclk) begin
                if (busy) started = 1;
                if (started && !busy && (done_total - done0) >= nf) begin
                    timed_out = 0;
                    break;
                end
                if (started) begin
                    if (!busy) n_gap++;
                    if (vsync) n_vs++;
                    if (hsync) begin
                        if (!prev_hs) begin
                            n_win++;
                            pos = 0;
                            if (first_hs < 0) first_hs = idx;
                        end
                        q_data.push_back(data);
                        q_pos.push_back(pos);
                        q_fidx.push_back(done_total - done0);
                        if (pos == int'(2 * HA - 1)) n_last_pos++;
                        pos++;
                        n_hs++;
                    end else if (data !== 8'h00) begin
                        n_blank_bad++;
                    end
                    prev_hs = hsync;
                    idx++;
                end
            end
            prev_pclk = pclk;
        end
    endtask

    task automatic test_reset;
        int highs;
        apply_reset;
        @(negedge clk_100MHz);
        rst_n = 1'b0;
        #1;
        n_checks++; if (pclk !== 1'b0) begin n_fail++; $display("FAIL reset_pclk: got %b want 0", pclk); end
        n_checks++; if (vsync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b want 0", vsync); end
        n_checks++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL reset_hsync: got %b want 0", hsync); end
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
        n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_100MHz);
            if (pclk === 1'b1) highs++;
        end
        n_checks++; if (highs != 8) begin n_fail++; $display("FAIL pclk_duty: got %0d high of 16 want 8", highs); end
        repeat (40) @(negedge clk_100MHz);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: busy got %b want 0", busy); end
    endtask

    task automatic test_single_frame;
        int d0;
        apply_reset;
        d0 = done_total;
        pulse_start;
        capture(1, CAP_CLKS);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL single_timeout: got 1 want 0"); end
        n_checks++; if (n_vs != int'(VS * LT)) begin n_fail++; $display("FAIL single_vsync_ticks: got %0d want %0d", n_vs, VS * LT); end
        n_checks++; if (first_hs != int'((VS + VB) * LT)) begin n_fail++; $display("FAIL single_first_hs: got %0d want %0d", first_hs, (VS + VB) * LT); end
        n_checks++; if (n_win != int'(VA)) begin n_fail++; $display("FAIL single_windows: got %0d want %0d", n_win, VA); end
        n_checks++; if (n_hs != int'(VA * 2 * HA)) begin n_fail++; $display("FAIL single_hs_ticks: got %0d want %0d", n_hs, VA * 2 * HA); end
        n_checks++; if (n_last_pos != int'(VA)) begin n_fail++; $display("FAIL single_window_len: got %0d full windows want %0d", n_last_pos, VA); end
        n_checks++; if (n_blank_bad != 0) begin n_fail++; $display("FAIL single_blank_data: got %0d nonzero want 0", n_blank_bad); end
        n_checks++; if (done_total - d0 != 1) begin n_fail++; $display("FAIL single_done: got %0d want 1", done_total - d0); end
        n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", frame_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

`ifndef PATTERN_CHECKER_EN
    task automatic test_gradient;
        logic [7:0] exp_b [16] = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h18, 8'h00,
                                   8'h00, 8'h20, 8'h08, 8'h20, 8'h10, 8'h20, 8'h18, 8'h20};
        apply_reset;
        pulse_start;
        capture(1, CAP_CLKS);
        n_checks++; if (q_data.size() != 16) begin n_fail++; $display("FAIL grad_count: got %0d want 16", q_data.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < q_data.size()) begin
                n_checks++;
                if (q_data[i] !== exp_b[i]) begin
                    n_fail++;
                    $display("FAIL grad_byte%0d: got %h want %h", i, q_data[i], exp_b[i]);
                end
            end
        end
    endtask
`else
    task automatic test_checker;
        logic [7:0] exp;
        apply_reset;
        pulse_start;
        capture(1, CAP_CLKS);
        n_checks++; if (q_data.size() != int'(VA * 2 * HA)) begin n_fail++; $display("FAIL chk_count: got %0d want %0d", q_data.size(), VA * 2 * HA); end
        for (int i = 0; i < int'(2 * HA); i++) begin
            exp = (i / 2 >= 8) ? 8'hFF : 8'h00;
            if (i < q_data.size()) begin
                n_checks++;
                if (q_data[i] !== exp) begin
                    n_fail++;
                    $display("FAIL chk_byte%0d: got %h want %h", i, q_data[i], exp);
                end
            end
        end
    endtask
`endif

    task automatic test_continuous;
        int d0;
        apply_reset;
        d0 = done_total;
        continuous = 1'b1;
        pulse_start;
        capture(3, 3 * CAP_CLKS);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL cont_timeout: got 1 want 0"); end
        n_checks++; if (done_total - d0 != 3) begin n_fail++; $display("FAIL cont_done: got %0d want 3", done_total - d0); end
        n_checks++; if (frame_cnt !== 8'd3) begin n_fail++; $display("FAIL cont_cnt: got %0d want 3", frame_cnt); end
        n_checks++; if (n_gap != 0) begin n_fail++; $display("FAIL cont_idle_gap: got %0d idle ticks want 0", n_gap); end
        n_checks++; if (n_vs != int'(3 * VS * LT)) begin n_fail++; $display("FAIL cont_vsync_ticks: got %0d want %0d", n_vs, 3 * VS * LT); end
        n_checks++; if (n_win != int'(3 * VA)) begin n_fail++; $display("FAIL cont_windows: got %0d want %0d", n_win, 3 * VA); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_busy_end: got %b want 0", busy); end
`ifndef PATTERN_CHECKER_EN
        for (int f = 0; f < 3; f++) begin
            int bad, seen;
            logic [7:0] b;
            logic [4:0] fb;
            bad = 0; seen = 0;
            fb = f[4:0];
            for (int i = 0; i < q_data.size(); i++) begin
                if (q_fidx[i] == f && q_pos[i] % 2 == 1) begin
                    b = q_data[i];
                    seen++;
                    if (b[4:0] !== fb) bad++;
                end
            end
            n_checks++;
            if (bad != 0 || seen != int'(VA * HA)) begin
                n_fail++;
                $display("FAIL cont_bfield_f%0d: got %0d bad of %0d want 0 bad of %0d", f, bad, seen, VA * HA);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_frame;
        int d0;
        bit found;
        apply_reset;
        pulse_start;
        capture(1, CAP_CLKS);
        pulse_start;
        found = 0;
        for (int c = 0; c < CAP_CLKS; c++) begin
            @(negedge clk_100MHz);
            if (hsync === 1'b1 && data !== 8'h00) begin
                found = 1;
                break;
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL mid_reach_act: got 0 want 1"); end
        d0 = done_total;
        rst_n = 1'b0;
        #1;
        n_checks++; if (pclk !== 1'b0) begin n_fail++; $display("FAIL mid_pclk: got %b want 0", pclk); end
        n_checks++; if (vsync !== 1'b0 || hsync !== 1'b0) begin n_fail++; $display("FAIL mid_syncs: got %b%b want 00", vsync, hsync); end
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL mid_data: got %h want 00", data); end
        n_checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_busy_done: got %b%b want 00", busy, frame_done); end
        n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d want 0", frame_cnt); end
        repeat (3) @(negedge clk_100MHz);
        rst_n = 1'b1;
        repeat (2 * FRAME_T * 4) @(negedge clk_100MHz);
        n_checks++; if (done_total != d0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses want 0", done_total - d0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_wait_idle: busy got %b want 0", busy); end
        pulse_start;
        capture(1, CAP_CLKS);
        n_checks++; if (done_total - d0 != 1) begin n_fail++; $display("FAIL mid_restart_done: got %0d want 1", done_total - d0); end
        n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_restart_cnt: got %0d want 1", frame_cnt); end
        n_checks++; if (n_hs != int'(VA * 2 * HA)) begin n_fail++; $display("FAIL mid_restart_hs: got %0d want %0d", n_hs, VA * 2 * HA); end
    endtask

    task automatic test_start_while_busy;
        int d0;
        apply_reset;
        d0 = done_total;
        pulse_start;
        repeat ((VS * LT + VB * LT / 2) * 4) @(negedge clk_100MHz);
        n_checks++; if (busy !== 1'b1 || vsync !== 1'b0 || hsync !== 1'b0) begin n_fail++; $display("FAIL busy_in_vbp: got busy=%b vs=%b hs=%b want 1,0,0", busy, vsync, hsync); end
        pulse_start;
        capture(1, CAP_CLKS);
        repeat (2 * FRAME_T * 4) @(negedge clk_100MHz);
        n_checks++; if (done_total - d0 != 1) begin n_fail++; $display("FAIL busy_done: got %0d want 1", done_total - d0); end
        n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL busy_cnt: got %0d want 1", frame_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_not_queued: busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset;
        test_single_frame;
`ifndef PATTERN_CHECKER_EN
        test_gradient;
`else
        test_checker;
`endif
        test_continuous;
        test_reset_mid_frame;
        test_start_while_busy;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
